alsu_seq: RTL and testbench
===========================

# alsu_seq

Multi-cycle, parametrised arithmetic/logic/shift unit with valid/ready handshakes on input and output, a registered result and flag set, and a stored carry flag for multi-word ADC/SBB chains. It extends the combinational ALSU with 4-bit function codes, variable-distance iterative shifts, an optional iterative multiplier and back-pressure. It sits between the decode/issue stage and writeback.

## Interface
- DATAWIDTH, 16, operand/result width; must be a power of two ≥ 4.
- SHW (localparam), $clog2(DATAWIDTH), width of the shift-amount field.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  high only in IDLE; accept occurs when IN_VALID && IN_READY.
- A, B  in  DATAWIDTH  operands, sampled only at accept.
- FUNC  in  4  operation code, sampled at accept.
- FLAG_WE  in  1  sampled at accept; when 1, the stored carry is updated from C when the operation completes.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  result consumed when OUT_VALID && OUT_READY.
- R  out  DATAWIDTH  registered result.
- Z, N, C  out  1  registered flags for R.
- ERR  out  1  registered; 1 for a reserved FUNC.

## Operation
- FUNC encoding:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 SHL
  - 3 SHR (logical)
  - 4 AND
  - 5 XOR
  - 6 NOT ~A
  - 7 INC A+1
  - 8 ADC A+B+cy
  - 9 SBB A−B−cy
  - 10 SAR (arithmetic)
  - 11 OR
  - 12 MUL (see Configuration)
  - 13–15 reserved
- cy is the internal stored carry register.
- Shift distance s = B[SHW−1:0]. Higher bits of B are ignored.
- Z = (R == 0). N = R[DATAWIDTH−1].
- C by operation:
  - ADD/ADC/INC: carry out.
  - SUB/SBB: borrow, 1 when A < B (+cy) unsigned.
  - Shifts: last bit shifted out; 0 when s = 0.
  - Logic ops: 0.
  - MUL: 1 if the upper product half is nonzero.
- R for MUL is the low DATAWIDTH bits of the product.
- Reserved FUNC: R=0, Z=1, N=0, C=0, ERR=1. ERR=0 for every defined FUNC.
- FSM states:
  - IDLE: IN_READY=1.
    - Accept of a single-cycle op (including reserved, and shifts with s=0) → DONE.
    - Accept of a shift with s>0 → SHIFT.
    - Accept of MUL → MUL.
  - SHIFT: one bit per cycle; down-counter loaded with s; → DONE when the count expires.
  - MUL: shift-add, one multiplier bit per cycle, DATAWIDTH cycles → DONE.
  - DONE: OUT_VALID=1. R/Z/N/C/ERR are held stable until OUT_READY; on handshake → IDLE.
- Stored carry (cy) is written with C on the DONE entry edge, only if FLAG_WE was 1 at accept.
- IN_VALID is ignored outside IDLE. A/B/FUNC changes after accept have no effect.

## Timing
- Reset (asynchronous, immediate) values:
  - State = IDLE.
  - IN_READY=1, OUT_VALID=0.
  - R=0, Z=0, N=0, C=0, ERR=0, cy=0.
- Reset during SHIFT/MUL/DONE aborts the operation. No result is produced, and cy is not updated.
- Latency, counted from the accept edge e0 to the first edge at which OUT_VALID=1:
  - Single-cycle ops: e0+1.
  - Shifts: e0+1+s.
  - MUL: e0+1+DATAWIDTH.
- Throughput: at most one operation per 2 cycles. IN_READY returns high the cycle after the output handshake.
- Back-to-back ADC/SBB with FLAG_WE=1 see the carry produced by the previous completed op.
- Boundary cases:
  - s=0 behaves as a single-cycle op.
  - s=DATAWIDTH−1 is the maximum distance.
  - SAR fills with A[DATAWIDTH−1].
  - INC of all-ones gives R=0, Z=1, C=1.

## Configuration
- ALSU_MUL_EN:
  - Defined: the MUL state and iterative multiplier are compiled in, and FUNC 12 performs MUL.
  - Undefined: no multiplier logic exists, and FUNC 12 is handled as a reserved code (R=0, Z=1, ERR=1, single-cycle).

## Test plan
All scenarios use DATAWIDTH=16.
- ADD A=3, B=10 → R=13, Z=0, N=0, C=0, OUT_VALID one cycle after accept. Then SUB A=3, B=10 → R=0xFFF9, N=1, C=1.
- Carry chain:
  - ADD 0xFFFF+0x0001 with FLAG_WE=1 → R=0, Z=1, C=1.
  - Then ADC A=0, B=0 → R=1, C=0.
  - Then SBB A=5, B=5 with cy=0 → R=0, Z=1.
- Shifts:
  - SHL A=0x8001, B=1 → R=0x0002, C=1, latency 2.
  - SHL A=0x8001, B=4 → R=0x0010, C=0, latency 5.
  - SAR A=0x8000, B=15 → R=0xFFFF, latency 16.
  - SHR with B=0x0010 (s=0) → R=A, C=0, latency 1.
- Back-pressure: hold OUT_READY=0 for 3 cycles after OUT_VALID rises while IN_VALID=1 with new operands → R/flags stable, IN_READY=0, no new accept. Release → handshake, then the next op is accepted.
- MUL with ALSU_MUL_EN defined:
  - 7×9 → R=63, C=0, latency 17.
  - 0x0100×0x0100 → R=0, Z=1, C=1.
  - Without the macro: FUNC=12 → ERR=1, R=0, latency 1. FUNC=15 → ERR=1 in both builds.
- Reset mid-operation: start SHL with B=15, assert RST 5 cycles after accept → OUT_VALID=0 and IN_READY=1 immediately, cy=0. After release, ADD 1+1 → R=2 with normal latency.

Source files
------------

// File: rtl/alsu_seq.sv
// Multi-cycle ALU/shift unit with valid/ready handshakes, registered result/flags and stored carry.
// Optional iterative multiplier (FUNC 12) compiled in when ALSU_MUL_EN is defined.
module alsu_seq #(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [3:0]           func,
    input  logic                 flag_we,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] r,
    output logic                 z,
    output logic                 n,
    output logic                 c,
    output logic                 err
);

    localparam int unsigned W   = DATAWIDTH;
    localparam int unsigned SHW = $clog2(DATAWIDTH);

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_SHL = 4'd2;
    localparam logic [3:0] F_SHR = 4'd3;
    localparam logic [3:0] F_AND = 4'd4;
    localparam logic [3:0] F_XOR = 4'd5;
    localparam logic [3:0] F_NOT = 4'd6;
    localparam logic [3:0] F_INC = 4'd7;
    localparam logic [3:0] F_ADC = 4'd8;
    localparam logic [3:0] F_SBB = 4'd9;
    localparam logic [3:0] F_SAR = 4'd10;
    localparam logic [3:0] F_OR  = 4'd11;
`ifdef ALSU_MUL_EN
    localparam logic [3:0] F_MUL = 4'd12;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   val, val_nxt;
    logic [SHW-1:0] cnt, cnt_nxt;
    logic [3:0]     func_q, func_nxt;
    logic           fwe_q, fwe_nxt;
    logic           cy, cy_nxt;
    logic [W-1:0]   r_nxt;
    logic           z_nxt, n_nxt, c_nxt, err_nxt;

    logic [W-1:0]   alu_r;
    logic           alu_c, alu_err, alu_multi;
    logic [W-1:0]   sh_val;
    logic           sh_bit;
    logic           fin, fin_c, fin_err, fin_we;
    logic [W-1:0]   fin_r;

`ifdef ALSU_MUL_EN
    logic [2*W-1:0] prod, prod_nxt;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;

    // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, val} : {(W+1){1'b0}});
        mul_step = {mul_sum, prod[W-1:1]};
    end
`endif

    // Single-cycle result from the live operands; flags ops that need the iterative datapath.
    always_comb begin
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_err   = 1'b0;
        alu_multi = 1'b0;
        case (func)
            F_ADD: {alu_c, alu_r} = {1'b0, a} + {1'b0, b};
            F_SUB: {alu_c, alu_r} = {1'b0, a} - {1'b0, b};
            F_ADC: {alu_c, alu_r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy};
            F_SBB: {alu_c, alu_r} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cy};
            F_INC: {alu_c, alu_r} = {1'b0, a} + {{W{1'b0}}, 1'b1};
            F_AND: alu_r = a & b;
            F_XOR: alu_r = a ^ b;
            F_OR:  alu_r = a | b;
            F_NOT: alu_r = ~a;
            F_SHL, F_SHR, F_SAR: begin
                alu_r     = a;
                alu_multi = (b[SHW-1:0] != '0);
            end
`ifdef ALSU_MUL_EN
            F_MUL: alu_multi = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // One-bit shift of the working value; sh_bit is the bit leaving the word.
    always_comb begin
        sh_val = val;
        sh_bit = 1'b0;
        case (func_q)
            F_SHL: begin
                sh_val = {val[W-2:0], 1'b0};
                sh_bit = val[W-1];
            end
            F_SHR: begin
                sh_val = {1'b0, val[W-1:1]};
                sh_bit = val[0];
            end
            default: begin
                sh_val = {val[W-1], val[W-1:1]};
                sh_bit = val[0];
            end
        endcase
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt = state;
        val_nxt   = val;
        cnt_nxt   = cnt;
        func_nxt  = func_q;
        fwe_nxt   = fwe_q;
        fin       = 1'b0;
        fin_r     = '0;
        fin_c     = 1'b0;
        fin_err   = 1'b0;
        fin_we    = fwe_q;
`ifdef ALSU_MUL_EN
        prod_nxt  = prod;
`endif
        r_nxt     = r;
        z_nxt     = z;
        n_nxt     = n;
        c_nxt     = c;
        err_nxt   = err;
        cy_nxt    = cy;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    func_nxt = func;
                    fwe_nxt  = flag_we;
                    val_nxt  = a;
                    if (!alu_multi) begin
                        fin     = 1'b1;
                        fin_r   = alu_r;
                        fin_c   = alu_c;
                        fin_err = alu_err;
                        fin_we  = flag_we;
                    end else begin
                        state_nxt = SHIFT;
                        cnt_nxt   = b[SHW-1:0];
`ifdef ALSU_MUL_EN
                        if (func == F_MUL) begin
                            state_nxt = MUL;
                            cnt_nxt   = '0;
                            prod_nxt  = {{W{1'b0}}, b};
                        end
`endif
                    end
                end
            end
            SHIFT: begin
                val_nxt = sh_val;
                cnt_nxt = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    fin   = 1'b1;
                    fin_r = sh_val;
                    fin_c = sh_bit;
                end
            end
`ifdef ALSU_MUL_EN
            MUL: begin
                prod_nxt = mul_step;
                cnt_nxt  = cnt + SHW'(1);
                if (cnt == SHW'(W - 1)) begin
                    fin   = 1'b1;
                    fin_r = mul_step[W-1:0];
                    fin_c = |mul_step[2*W-1:W];
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Result capture; the stored carry only moves on completion of a flag-writing op.
        if (fin) begin
            state_nxt = DONE;
            r_nxt     = fin_r;
            z_nxt     = (fin_r == '0);
            n_nxt     = fin_r[W-1];
            c_nxt     = fin_c;
            err_nxt   = fin_err;
            if (fin_we) begin
                cy_nxt = fin_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            val       <= '0;
            cnt       <= '0;
            func_q    <= '0;
            fwe_q     <= 1'b0;
            cy        <= 1'b0;
            r         <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            err       <= 1'b0;
`ifdef ALSU_MUL_EN
            prod      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            val       <= val_nxt;
            cnt       <= cnt_nxt;
            func_q    <= func_nxt;
            fwe_q     <= fwe_nxt;
            cy        <= cy_nxt;
            r         <= r_nxt;
            z         <= z_nxt;
            n         <= n_nxt;
            c         <= c_nxt;
            err       <= err_nxt;
`ifdef ALSU_MUL_EN
            prod      <= prod_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alsu_seq.sv
// Self-checking bench for alsu_seq (DATAWIDTH=16): directed cases plus random ops against an arithmetic model.
module tb_alsu_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   func;
    logic         flag_we;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic m_cy;

    always #5 clk = ~clk;

    alsu_seq #(.DATAWIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .func(func),
        .flag_we(flag_we),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r(r),
        .z(z),
        .n(n),
        .c(c),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result, carry, error and latency from the operation's arithmetic definition.
    function automatic void model(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, output logic [15:0] rr, output logic cc,
                                  output logic ee, output int lat);
        int t;
        int s;
        longint p;
        s   = int'(y[3:0]);
        t   = 0;
        p   = 0;
        rr  = '0;
        cc  = 1'b0;
        ee  = 1'b0;
        lat = 1;
        case (f)
            4'd0:  begin t = int'(x) + int'(y); rr = 16'(t); cc = (t > 65535); end
            4'd1:  begin rr = x - y; cc = (x < y); end
            4'd2:  begin rr = x << s; cc = (s == 0) ? 1'b0 : x[16-s]; lat = 1 + s; end
            4'd3:  begin rr = x >> s; cc = (s == 0) ? 1'b0 : x[s-1]; lat = 1 + s; end
            4'd4:  rr = x & y;
            4'd5:  rr = x ^ y;
            4'd6:  rr = ~x;
            4'd7:  begin t = int'(x) + 1; rr = 16'(t); cc = (t > 65535); end
            4'd8:  begin t = int'(x) + int'(y) + int'(ci); rr = 16'(t); cc = (t > 65535); end
            4'd9:  begin t = int'(x) - int'(y) - int'(ci); rr = 16'(t); cc = (t < 0); end
            4'd10: begin rr = 16'($signed(x) >>> s); cc = (s == 0) ? 1'b0 : x[s-1]; lat = 1 + s; end
            4'd11: rr = x | y;
`ifdef ALSU_MUL_EN
            4'd12: begin p = longint'(x) * longint'(y); rr = 16'(p); cc = ((p >> 16) != 0); lat = 17; end
`endif
            default: ee = 1'b1;
        endcase
    endfunction

    // Issue one op, check latency/result, optionally stall the output for hold cycles, then hand off.
    task automatic do_op(input logic [3:0] f, input logic [15:0] av, input logic [15:0] bv,
                         input logic we, input int hold);
        logic [15:0] er;
        logic        ec;
        logic        ee;
        int          el;
        int          lat;
        model(f, av, bv, m_cy, er, ec, ee, el);
        check("idle_ready", 32'(in_ready), 32'd1);
        func      = f;
        a         = av;
        b         = bv;
        flag_we   = we;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        a       = 16'($urandom);
        b       = 16'($urandom);
        func    = 4'($urandom);
        flag_we = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(el));
        check("r", 32'(r), 32'(er));
        check("z", 32'(z), 32'(er == 16'h0));
        check("n", 32'(n), 32'(er[15]));
        check("c", 32'(c), 32'(ec));
        check("err", 32'(err), 32'(ee));
        if (we) m_cy = ec;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_r", 32'(r), 32'(er));
            check("bp_c", 32'(c), 32'(ec));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        func      = '0;
        flag_we   = 1'b0;
        m_cy      = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_flags", 32'({z, n, c, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(4'd0, 16'd3, 16'd10, 1'b0, 0);
        do_op(4'd1, 16'd3, 16'd10, 1'b0, 0);
        do_op(4'd0, 16'hFFFF, 16'h0001, 1'b1, 0);
        do_op(4'd8, 16'h0000, 16'h0000, 1'b1, 0);
        do_op(4'd9, 16'd5, 16'd5, 1'b1, 0);
        do_op(4'd2, 16'h8001, 16'd1, 1'b0, 0);
        do_op(4'd2, 16'h8001, 16'd4, 1'b0, 0);
        do_op(4'd10, 16'h8000, 16'd15, 1'b0, 0);
        do_op(4'd3, 16'h1234, 16'h0010, 1'b0, 0);
        do_op(4'd7, 16'hFFFF, 16'h0000, 1'b0, 0);
        do_op(4'd0, 16'd100, 16'd200, 1'b0, 3);
        do_op(4'd1, 16'd7, 16'd3, 1'b0, 0);
        do_op(4'd12, 16'd7, 16'd9, 1'b0, 0);
        do_op(4'd12, 16'h0100, 16'h0100, 1'b0, 0);
        do_op(4'd15, 16'd1, 16'd2, 1'b0, 0);

        // Set cy, then abort a long shift with reset; cy must come back cleared.
        do_op(4'd0, 16'hFFFF, 16'h0001, 1'b1, 0);
        func     = 4'd2;
        a        = 16'h0001;
        b        = 16'd15;
        flag_we  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        m_cy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(4'd8, 16'h0000, 16'h0000, 1'b0, 0);
        do_op(4'd0, 16'd1, 16'd1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom),
                  (i % 5 == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
